// File: rtl/y86_pkg.sv
// Shared Y86 encodings, the M-stage bubble constant and the condition-code struct
// used by the execute stage and its ALU.
package y86_pkg;

   localparam logic [3:0] I_HALT  = 4'h0;
   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_CMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;

   localparam logic [3:0] F_ADD = 4'h0;
   localparam logic [3:0] F_SUB = 4'h1;
   localparam logic [3:0] F_AND = 4'h2;
   localparam logic [3:0] F_XOR = 4'h3;
   localparam logic [3:0] F_MUL = 4'h4;

   localparam logic [3:0] C_ALL = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_HLT = 3'd2;
   localparam logic [2:0] S_ADR = 3'd3;
   localparam logic [2:0] S_INS = 3'd4;

   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_XOR,
      ALU_MUL
   } alu_fn_t;

   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_t;

   localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

   typedef struct packed {
      logic [2:0] stat;
      logic [3:0] icode;
      logic       cnd;
   } m_ctl_t;

   localparam m_ctl_t M_CTL_BUBBLE = '{stat: S_AOK, icode: I_NOP, cnd: 1'b0};

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86 ALU: add, sub (b - a), and, xor, mul with two's-complement flags.
module y86_alu
   import y86_pkg::*;
#(
   parameter int unsigned DATA_W = 64
) (
   input  logic [DATA_W-1:0] alu_a,
   input  logic [DATA_W-1:0] alu_b,
   input  alu_fn_t           fn,
   output logic [DATA_W-1:0] result,
   output logic              zf,
   output logic              sf,
   output logic              of
);

   logic sa, sb, sr;

   assign sa = alu_a[DATA_W-1];
   assign sb = alu_b[DATA_W-1];
   assign sr = result[DATA_W-1];

   always_comb begin
      result = '0;
      case (fn)
         ALU_ADD: result = alu_b + alu_a;
         ALU_SUB: result = alu_b - alu_a;
         ALU_AND: result = alu_b & alu_a;
         ALU_XOR: result = alu_b ^ alu_a;
         // low DATA_W bits of a product are the same for signed and unsigned operands
         ALU_MUL: result = alu_b * alu_a;
         default: result = alu_b + alu_a;
      endcase
   end

   always_comb begin
      of = 1'b0;
      case (fn)
         ALU_ADD: of = (sa == sb) && (sr != sa);
         ALU_SUB: of = (sb != sa) && (sr != sb);
         default: of = 1'b0;
      endcase
   end

   assign zf = (result == '0);
   assign sf = sr;

endmodule

// File: rtl/y86_execute_pipe.sv
// Y86 execute stage: operand select, ALU, clocked condition codes, multi-cycle mulq
// sequencing and the E->M pipeline register.
module y86_execute_pipe
   import y86_pkg::*;
#(
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned REG_W   = 4,
   parameter int unsigned STAT_W  = 3,
   parameter int unsigned MUL_LAT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [STAT_W-1:0] E_stat,
   input  logic [3:0]        E_icode,
   input  logic [3:0]        E_ifun,
   input  logic [DATA_W-1:0] E_valA,
   input  logic [DATA_W-1:0] E_valB,
   input  logic [DATA_W-1:0] E_valC,
   input  logic [REG_W-1:0]  E_dstE,
   input  logic [REG_W-1:0]  E_dstM,
   input  logic [STAT_W-1:0] m_stat,
   input  logic [STAT_W-1:0] W_stat,
   input  logic              M_stall,
   input  logic              M_bubble,
   output logic [DATA_W-1:0] e_valE,
   output logic [REG_W-1:0]  e_dstE,
   output logic              e_Cnd,
   output logic              e_busy,
   output logic [2:0]        cc_out,
   output logic [STAT_W-1:0] M_stat,
   output logic [3:0]        M_icode,
   output logic              M_Cnd,
   output logic [DATA_W-1:0] M_valE,
   output logic [DATA_W-1:0] M_valA,
   output logic [REG_W-1:0]  M_dstE,
   output logic [REG_W-1:0]  M_dstM
);

   localparam int unsigned       CNT_W     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MUL_LAT - 1);
   localparam logic [REG_W-1:0]  R_NONE    = '1;
   localparam logic [DATA_W-1:0] EIGHT     = DATA_W'(8);
   localparam logic [DATA_W-1:0] NEG_EIGHT = ~EIGHT + DATA_W'(1);

   logic [DATA_W-1:0] alu_a, alu_b;
   alu_fn_t           fn;
   logic              alu_zf, alu_sf, alu_of;
   logic [CNT_W-1:0]  cnt;
   logic              is_mul, cc_set;
   cc_t               cc;

   function automatic logic is_exc(input logic [STAT_W-1:0] s);
      return (s == STAT_W'(S_HLT)) || (s == STAT_W'(S_ADR)) || (s == STAT_W'(S_INS));
   endfunction

   always_comb begin
      alu_a = '0;
      case (E_icode)
         I_CMOV, I_OPQ:             alu_a = E_valA;
         I_IRMOV, I_RMMOV, I_MRMOV: alu_a = E_valC;
         I_CALL, I_PUSH:            alu_a = NEG_EIGHT;
         I_RET, I_POP:              alu_a = EIGHT;
         default:                   alu_a = '0;
      endcase
   end

   always_comb begin
      alu_b = '0;
      case (E_icode)
         I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_PUSH, I_RET, I_POP: alu_b = E_valB;
         default:                                               alu_b = '0;
      endcase
   end

   always_comb begin
      fn = ALU_ADD;
      if (E_icode == I_OPQ) begin
         case (E_ifun)
            F_SUB:   fn = ALU_SUB;
            F_AND:   fn = ALU_AND;
            F_XOR:   fn = ALU_XOR;
            F_MUL:   fn = ALU_MUL;
            default: fn = ALU_ADD;
         endcase
      end
   end

   y86_alu #(.DATA_W(DATA_W)) u_alu (
      .alu_a  (alu_a),
      .alu_b  (alu_b),
      .fn     (fn),
      .result (e_valE),
      .zf     (alu_zf),
      .sf     (alu_sf),
      .of     (alu_of)
   );

   always_comb begin
      e_Cnd = 1'b0;
      if (E_icode == I_CMOV || E_icode == I_JXX) begin
         case (E_ifun)
            C_ALL:   e_Cnd = 1'b1;
            C_LE:    e_Cnd = (cc.sf ^ cc.of) | cc.zf;
            C_L:     e_Cnd = cc.sf ^ cc.of;
            C_E:     e_Cnd = cc.zf;
            C_NE:    e_Cnd = ~cc.zf;
            C_GE:    e_Cnd = ~(cc.sf ^ cc.of);
            C_G:     e_Cnd = ~(cc.sf ^ cc.of) & ~cc.zf;
            default: e_Cnd = 1'b0;
         endcase
      end
   end

   assign e_dstE = (E_icode == I_CMOV && !e_Cnd) ? R_NONE : E_dstE;

   // busy is gated by rst_n so it drops the moment reset asserts, not at the next edge
   assign is_mul = (E_icode == I_OPQ) && (E_ifun == F_MUL);
   assign e_busy = rst_n && is_mul && (cnt != CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (!is_mul || cnt == CNT_LAST)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

   assign cc_set = (E_icode == I_OPQ) && !is_exc(m_stat) && !is_exc(W_stat) && !e_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cc <= CC_RESET;
      else if (cc_set)
         cc <= '{zf: alu_zf, sf: alu_sf, of: alu_of};
   end

   assign cc_out = cc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         M_stat  <= STAT_W'(M_CTL_BUBBLE.stat);
         M_icode <= M_CTL_BUBBLE.icode;
         M_Cnd   <= M_CTL_BUBBLE.cnd;
         M_valE  <= '0;
         M_valA  <= '0;
         M_dstE  <= R_NONE;
         M_dstM  <= R_NONE;
      end else if (M_stall) begin
         M_stat  <= M_stat;
      end else if (M_bubble || e_busy) begin
         M_stat  <= STAT_W'(M_CTL_BUBBLE.stat);
         M_icode <= M_CTL_BUBBLE.icode;
         M_Cnd   <= M_CTL_BUBBLE.cnd;
         M_valE  <= '0;
         M_valA  <= '0;
         M_dstE  <= R_NONE;
         M_dstM  <= R_NONE;
      end else begin
         M_stat  <= E_stat;
         M_icode <= E_icode;
         M_Cnd   <= e_Cnd;
         M_valE  <= e_valE;
         M_valA  <= E_valA;
         M_dstE  <= e_dstE;
         M_dstM  <= E_dstM;
      end
   end

endmodule

// File: tb/tb_y86_execute_pipe.sv
// Directed self-checking bench for y86_execute_pipe with hand-computed expectations.
module tb_y86_execute_pipe;

   logic        clk;
   logic        rst_n;
   logic [2:0]  E_stat;
   logic [3:0]  E_icode, E_ifun;
   logic [63:0] E_valA, E_valB, E_valC;
   logic [3:0]  E_dstE, E_dstM;
   logic [2:0]  m_stat, W_stat;
   logic        M_stall, M_bubble;
   logic [63:0] e_valE;
   logic [3:0]  e_dstE;
   logic        e_Cnd, e_busy;
   logic [2:0]  cc_out;
   logic [2:0]  M_stat;
   logic [3:0]  M_icode;
   logic        M_Cnd;
   logic [63:0] M_valE, M_valA;
   logic [3:0]  M_dstE, M_dstM;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   y86_execute_pipe #(
      .DATA_W  (64),
      .REG_W   (4),
      .STAT_W  (3),
      .MUL_LAT (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .E_stat   (E_stat),
      .E_icode  (E_icode),
      .E_ifun   (E_ifun),
      .E_valA   (E_valA),
      .E_valB   (E_valB),
      .E_valC   (E_valC),
      .E_dstE   (E_dstE),
      .E_dstM   (E_dstM),
      .m_stat   (m_stat),
      .W_stat   (W_stat),
      .M_stall  (M_stall),
      .M_bubble (M_bubble),
      .e_valE   (e_valE),
      .e_dstE   (e_dstE),
      .e_Cnd    (e_Cnd),
      .e_busy   (e_busy),
      .cc_out   (cc_out),
      .M_stat   (M_stat),
      .M_icode  (M_icode),
      .M_Cnd    (M_Cnd),
      .M_valE   (M_valE),
      .M_valA   (M_valA),
      .M_dstE   (M_dstE),
      .M_dstM   (M_dstM)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_e(input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                        input logic [3:0] de, input logic [3:0] dm);
      E_stat  = 3'd1;
      E_icode = icode;
      E_ifun  = ifun;
      E_valA  = va;
      E_valB  = vb;
      E_valC  = vc;
      E_dstE  = de;
      E_dstM  = dm;
   endtask

   task automatic check_bubble(input string tag);
      chk({tag, "_icode"}, 64'(M_icode), 64'h1);
      chk({tag, "_stat"},  64'(M_stat),  64'h1);
      chk({tag, "_valE"},  M_valE,       64'h0);
      chk({tag, "_dstE"},  64'(M_dstE),  64'hF);
      chk({tag, "_dstM"},  64'(M_dstM),  64'hF);
   endtask

   initial begin
      rst_n    = 1'b0;
      m_stat   = 3'd1;
      W_stat   = 3'd1;
      M_stall  = 1'b0;
      M_bubble = 1'b0;
      set_e(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
      #12;
      check_bubble("reset");
      chk("reset_cc",   64'(cc_out), 64'h4);
      chk("reset_busy", 64'(e_busy), 64'h0);
      rst_n = 1'b1;
      tick();

      // addq overflow to the sign bit
      set_e(4'h6, 4'h0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h3, 4'hF);
      #1;
      chk("add_e_valE", e_valE, 64'h8000_0000_0000_0000);
      chk("add_e_dstE", 64'(e_dstE), 64'h3);
      tick();
      chk("add_M_valE",  M_valE, 64'h8000_0000_0000_0000);
      chk("add_M_icode", 64'(M_icode), 64'h6);
      chk("add_M_valA",  M_valA, 64'h1);
      chk("add_M_dstE",  64'(M_dstE), 64'h3);
      chk("add_cc",      64'(cc_out), 64'h3);

      // subq 5 from 5
      set_e(4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 4'h2, 4'hF);
      tick();
      chk("sub_M_valE", M_valE, 64'h0);
      chk("sub_cc",     64'(cc_out), 64'h4);

      // cmovne with ZF set: not taken
      set_e(4'h2, 4'h4, 64'h1234, 64'h0, 64'h0, 4'h4, 4'hF);
      #1;
      chk("cmovne_cnd",  64'(e_Cnd), 64'h0);
      chk("cmovne_dstE", 64'(e_dstE), 64'hF);
      chk("cmovne_valE", e_valE, 64'h1234);
      tick();
      chk("cmovne_M_dstE", 64'(M_dstE), 64'hF);
      chk("cmovne_M_Cnd",  64'(M_Cnd), 64'h0);
      chk("cmovne_cc",     64'(cc_out), 64'h4);

      // cmove with ZF set: taken; jxx ifun 7 never taken
      set_e(4'h2, 4'h3, 64'h1234, 64'h0, 64'h0, 4'h4, 4'hF);
      #1;
      chk("cmove_cnd",  64'(e_Cnd), 64'h1);
      chk("cmove_dstE", 64'(e_dstE), 64'h4);
      set_e(4'h7, 4'h7, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
      #1;
      chk("jxx7_cnd", 64'(e_Cnd), 64'h0);
      tick();

      // CC suppressed by an exception downstream; M still loads
      m_stat = 3'd3;
      set_e(4'h6, 4'h0, 64'h2, 64'h3, 64'h0, 4'h1, 4'hF);
      tick();
      chk("madr_M_valE", M_valE, 64'h5);
      chk("madr_cc",     64'(cc_out), 64'h4);
      m_stat = 3'd1;
      W_stat = 3'd2;
      tick();
      chk("whlt_cc", 64'(cc_out), 64'h4);
      W_stat = 3'd1;

      // andq, then address arithmetic paths
      set_e(4'h6, 4'h2, 64'hF0, 64'h3C, 64'h0, 4'h1, 4'hF);
      tick();
      chk("and_M_valE", M_valE, 64'h30);
      chk("and_cc",     64'(cc_out), 64'h0);
      set_e(4'h5, 4'h0, 64'h0, 64'h20, 64'h10, 4'hF, 4'h7);
      #1;
      chk("mrmov_valE", e_valE, 64'h30);
      tick();
      set_e(4'hA, 4'h0, 64'h99, 64'h100, 64'h0, 4'h4, 4'hF);
      #1;
      chk("push_valE", e_valE, 64'hF8);
      tick();
      chk("push_M_icode", 64'(M_icode), 64'hA);

      // mulq 3 * -2, latency 4
      set_e(4'h6, 4'h4, 64'h3, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 4'h5, 4'hF);
      #1;
      chk("mul_busy0", 64'(e_busy), 64'h1);
      tick();
      chk("mul_busy1", 64'(e_busy), 64'h1);
      check_bubble("mul_b1");
      chk("mul_cc1", 64'(cc_out), 64'h0);
      tick();
      chk("mul_busy2", 64'(e_busy), 64'h1);
      check_bubble("mul_b2");
      tick();
      chk("mul_busy3", 64'(e_busy), 64'h0);
      chk("mul_e_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFA);
      check_bubble("mul_b3");
      tick();
      chk("mul_M_valE",  M_valE, 64'hFFFF_FFFF_FFFF_FFFA);
      chk("mul_M_icode", 64'(M_icode), 64'h6);
      chk("mul_M_dstE",  64'(M_dstE), 64'h5);
      chk("mul_cc",      64'(cc_out), 64'h2);

      // stall and bubble together: stall wins, CC still updates
      set_e(4'h6, 4'h0, 64'h1, 64'h1, 64'h0, 4'h6, 4'hF);
      M_stall  = 1'b1;
      M_bubble = 1'b1;
      tick();
      chk("stall_M_valE",  M_valE, 64'hFFFF_FFFF_FFFF_FFFA);
      chk("stall_M_icode", 64'(M_icode), 64'h6);
      chk("stall_M_dstE",  64'(M_dstE), 64'h5);
      chk("stall_cc",      64'(cc_out), 64'h0);
      M_stall = 1'b0;
      tick();
      check_bubble("bubble");
      M_bubble = 1'b0;
      tick();
      chk("load_M_valE", M_valE, 64'h2);
      chk("load_M_dstE", 64'(M_dstE), 64'h6);

      // reset during the second multiply cycle
      set_e(4'h6, 4'h4, 64'h3, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 4'h5, 4'hF);
      tick();
      tick();
      chk("rmul_busy_pre", 64'(e_busy), 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rmul_busy_rst", 64'(e_busy), 64'h0);
      chk("rmul_cc_rst",   64'(cc_out), 64'h4);
      check_bubble("rmul_rst");
      tick();
      chk("rmul_busy_rst2", 64'(e_busy), 64'h0);
      chk("rmul_valE_rst2", M_valE, 64'h0);
      #3;
      rst_n = 1'b1;
      #1;
      chk("rmul_busy_rel", 64'(e_busy), 64'h1);
      tick();
      chk("rmul_busy_c1", 64'(e_busy), 64'h1);
      check_bubble("rmul_c1");
      tick();
      tick();
      chk("rmul_busy_c3", 64'(e_busy), 64'h0);
      check_bubble("rmul_c3");
      tick();
      chk("rmul_M_valE", M_valE, 64'hFFFF_FFFF_FFFF_FFFA);
      chk("rmul_cc",     64'(cc_out), 64'h2);
      set_e(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/y86_execute_pipe.md
Name: y86_execute_pipe

Overview:
- Parametrised next-generation Y86 execute stage: ALU operand selection, ALU with correct signed flags, an architectural condition-code (CC) register, and the E→M pipeline register, all in one block.
- Adds capabilities the current stage lacks:
  - clocked CC with exception-based set suppression;
  - stall/bubble control of the M register;
  - multi-cycle `mulq` (OPq ifun 4) with a busy handshake to the hazard unit.
- Sits between the D/E register and the memory stage.

Parameters:
- DATA_W, 64, datapath width (valA/valB/valC/valE).
- REG_W, 4, register-ID width; all-ones value = RNONE.
- STAT_W, 3, status width.
- MUL_LAT, 4, mulq latency in cycles (≥1; 1 = single-cycle, no busy).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- E_stat  in  STAT_W  status of instruction in E.
- E_icode, E_ifun  in  4 each  instruction code/function.
- E_valA, E_valB, E_valC  in  DATA_W  operands.
- E_dstE, E_dstM  in  REG_W  destination IDs.
- m_stat  in  STAT_W  current memory-stage status (CC suppression).
- W_stat  in  STAT_W  current write-back-stage status (CC suppression).
- M_stall  in  1  hold M register.
- M_bubble  in  1  load bubble into M register.
- e_valE  out  DATA_W  combinational ALU result (forwarding).
- e_dstE  out  REG_W  combinational effective dstE (forwarding).
- e_Cnd  out  1  combinational condition.
- e_busy  out  1  mulq in progress; hazard unit stalls F/D/E.
- cc_out  out  3  {ZF,SF,OF} registered.
- M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM  out  (widths as E-side)  registered M stage.

Behaviour:
- Encodings:
  - icode: HALT 0, NOP 1, CMOV 2, IRMOV 3, RMMOV 4, MRMOV 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSH A, POP B.
  - stat: AOK 1, HLT 2, ADR 3, INS 4.
- aluA:
  - valA for CMOV/OPQ;
  - valC for IRMOV/RMMOV/MRMOV;
  - −8 for CALL/PUSH;
  - +8 for RET/POP;
  - 0 otherwise (no latches).
- aluB: valB for RMMOV/MRMOV/OPQ/CALL/PUSH/RET/POP; 0 otherwise.
- ALU function:
  - OPQ ifun: 0 add, 1 sub (aluB−aluA), 2 and, 3 xor, 4 mul;
  - every other icode is add;
  - OPQ ifun>4 behaves as add.
- Flags, all computed modulo 2^DATA_W:
  - ZF = result==0; SF = result[MSB].
  - OF (add) = sign(A)==sign(B) && sign(R)≠sign(A).
  - OF (sub) = sign(B)≠sign(A) && sign(R)≠sign(B).
  - OF = 0 for and/xor/mul.
  - mul result = low DATA_W bits of the signed product.
- CC register:
  - reset {ZF,SF,OF}=3'b100.
  - Updated at clk edge when E_icode==OPQ, no m_stat∈{ADR,INS,HLT}, no W_stat∈{ADR,INS,HLT}, and e_busy==0.
  - Otherwise holds.
- e_Cnd: evaluated from the registered CC, only for CMOV/JXX; 0 for all other icodes.
  - ifun 0 always; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne ~ZF; 5 ge ~(SF^OF); 6 g ~(SF^OF)&~ZF; >6 gives 0.
- e_dstE = RNONE when icode==CMOV && !e_Cnd; otherwise E_dstE.
- Multiply sequencing:
  - Counter cnt, width clog2(MUL_LAT), reset 0.
  - While E holds OPQ/mul and cnt≠MUL_LAT−1: e_busy=1, cnt increments.
  - When cnt==MUL_LAT−1: e_busy=0, result valid, cnt returns to 0.
  - cnt clears to 0 whenever E does not hold mul.
- M register update priority at clk edge:
  - reset → bubble;
  - else M_stall → hold;
  - else M_bubble or e_busy → bubble;
  - else load {E_stat, E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM}.
  - Bubble = stat AOK, icode NOP, Cnd 0, valE/valA 0, dstE/dstM RNONE.
- M_stall and M_bubble both high: stall wins.
- Reset mid-multiply: cnt→0, e_busy deasserts immediately, the mul restarts from cnt 0 after reset.
- Latency: 1 cycle from E to M; MUL_LAT cycles for mul.

Decomposition:
- Shared package y86_pkg holds:
  - icode/ifun/stat constants;
  - RNONE;
  - the bubble constant;
  - the cc struct {zf,sf,of}.
- One sub-module, y86_alu (parametrised DATA_W), is combinational: operands + fn → result, zf, sf, of.
- Sequencing, CC and the M register stay in the top level.

Test Plan:
- OPQ add 0x7FFF_FFFF_FFFF_FFFF + 1 → M_valE=0x8000_0000_0000_0000 next cycle; cc_out=3'b011 (SF, OF).
- subq 5 from 5, then cmovne rA→rB → CC ZF=1; cmov e_Cnd=0, e_dstE=0xF, M_dstE=0xF.
- OPQ with m_stat=ADR → cc_out unchanged from prior value; M still loads valE.
- mulq 3×(−2), MUL_LAT=4 → e_busy high 3 cycles, M shows bubble 3 cycles, then M_valE=−6 and cc_out=3'b010.
- M_stall and M_bubble both high with valid E → M unchanged; M_bubble alone → NOP/RNONE bubble.
- rst_n low during mul cycle 2 → M bubble and e_busy=0 during reset; cc_out=3'b100; mul completes MUL_LAT cycles after release.
